// File: rtl/mips_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | mips_ctrl_pkg : opcodes, state encodings and control-word type        |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RT    = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_ALUWB  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_outdec.sv
// +----------------------------------------------------------------------+
// | multicycle_ctrl_outdec : state + mem_ready to control-word decoder    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_t cur_state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    case (cur_state)
      ST_FETCH: begin
        ctrl.memread  = 1'b1;
        ctrl.alusrcb  = SRCB_FOUR;
        ctrl.aluop    = ALUOP_ADD;
        ctrl.pcsource = PCSRC_ALU;
        // IR and PC only advance once the fetch actually completes
        ctrl.irwrite  = mem_ready;
        ctrl.pcwrite  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alusrca = 1'b0;
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      ST_MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      ST_EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_RT;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_RT;
        ctrl.aluop       = ALUOP_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      ST_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      ST_ADDIWB: begin
        ctrl.regwrite = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// +----------------------------------------------------------------------+
// | multicycle_control : main control FSM of the multicycle MIPS datapath |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               memtoreg,
  output logic               regdst,
  output logic               regwrite,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  state_t r_state;
  state_t w_next;
  logic   w_illegal;
  ctrl_t  w_ctrl;
  ctrl_t  w_ctrl_gated;
  logic   w_unused_zero;

  // The branch decision is made in the datapath from pcwritecond and zero
  assign w_unused_zero = zero;

  always_comb begin
    w_next    = r_state;
    w_illegal = 1'b0;
    case (r_state)
      ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_RTYPE:     w_next = ST_EXEC;
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          OP_ADDI:      w_next = ST_ADDIEX;
          default: begin
            w_next    = ST_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      ST_MEMADR: begin
        if (op == OP_LW)      w_next = ST_MEMRD;
        else if (op == OP_SW) w_next = ST_MEMWR;
        else                  w_next = ST_FETCH;
      end
      ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   w_next = ST_ALUWB;
      ST_ADDIEX: w_next = ST_ADDIWB;
      default:   w_next = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  multicycle_ctrl_outdec u_outdec (
    .cur_state (r_state),
    .mem_ready (mem_ready),
    .ctrl      (w_ctrl)
  );

  // Outputs are forced low combinationally so a strobe dies the instant reset rises
  assign w_ctrl_gated = reset ? '0 : w_ctrl;

  assign pcwrite     = w_ctrl_gated.pcwrite;
  assign pcwritecond = w_ctrl_gated.pcwritecond;
  assign iord        = w_ctrl_gated.iord;
  assign memread     = w_ctrl_gated.memread;
  assign memwrite    = w_ctrl_gated.memwrite;
  assign irwrite     = w_ctrl_gated.irwrite;
  assign memtoreg    = w_ctrl_gated.memtoreg;
  assign regdst      = w_ctrl_gated.regdst;
  assign regwrite    = w_ctrl_gated.regwrite;
  assign alusrca     = w_ctrl_gated.alusrca;
  assign alusrcb     = w_ctrl_gated.alusrcb;
  assign aluop       = w_ctrl_gated.aluop;
  assign pcsource    = w_ctrl_gated.pcsource;
  assign illegal_op  = w_illegal & ~reset;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_control : directed bench for multicycle_control         |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int ir_cnt, mw_cnt, rw_cnt, pwc_cnt;

  logic [16:0] ctl;
  assign ctl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg,
                regdst, regwrite, alusrca, alusrcb, aluop, pcsource, illegal_op};

  multicycle_control #(.OP_W(6), .STATE_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .illegal_op(illegal_op), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, apply mem_ready for the new cycle, then let outputs settle
  task automatic step(input logic mr);
    @(posedge clk);
    #1 mem_ready = mr;
    #1;
    ir_cnt  += int'(irwrite);
    mw_cnt  += int'(memwrite);
    rw_cnt  += int'(regwrite);
    pwc_cnt += int'(pcwritecond);
    check_eq("excl_pc", {31'd0, pcwrite & pcwritecond}, 32'd0);
    check_eq("excl_mem", {31'd0, memread & memwrite}, 32'd0);
  endtask

  task automatic clr_cnt();
    ir_cnt = 0; mw_cnt = 0; rw_cnt = 0; pwc_cnt = 0;
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; zero = 1'b0; mem_ready = 1'b1;
    clr_cnt();
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_ctl", {15'd0, ctl}, 32'd0);
    check_eq("rst_state", {28'd0, state}, 32'd0);

    // release, then R-type
    @(negedge clk);
    reset = 1'b0; op = 6'b000000; mem_ready = 1'b1;
    #1;
    check_eq("fetch_state", {28'd0, state}, 32'd0);
    check_eq("fetch_memread", {31'd0, memread}, 32'd1);
    check_eq("fetch_irwrite", {31'd0, irwrite}, 32'd1);
    check_eq("fetch_srcb", {30'd0, alusrcb}, 32'd1);
    step(1'b1);
    check_eq("r_dec", {28'd0, state}, 32'd1);
    check_eq("r_dec_srcb", {30'd0, alusrcb}, 32'd3);
    step(1'b1);
    check_eq("r_exec", {28'd0, state}, 32'd6);
    check_eq("r_exec_aluop", {30'd0, aluop}, 32'd2);
    check_eq("r_exec_rw", {31'd0, regwrite}, 32'd0);
    step(1'b1);
    check_eq("r_wb", {28'd0, state}, 32'd7);
    check_eq("r_wb_rw_rd", {30'd0, regwrite, regdst}, 32'd3);
    step(1'b1);
    check_eq("r_back", {28'd0, state}, 32'd0);

    // lw: 2 stall cycles in FETCH, 3 in MEMRD
    op = 6'b100011;
    clr_cnt();
    mem_ready = 1'b0;
    #1;
    ir_cnt += int'(irwrite);
    check_eq("lw_f_stall_ir", {31'd0, irwrite}, 32'd0);
    step(1'b0);
    check_eq("lw_f1", {28'd0, state}, 32'd0);
    step(1'b1);
    check_eq("lw_f2", {28'd0, state}, 32'd0);
    step(1'b1);
    check_eq("lw_dec", {28'd0, state}, 32'd1);
    step(1'b1);
    check_eq("lw_madr", {28'd0, state}, 32'd2);
    check_eq("lw_madr_src", {29'd0, alusrca, alusrcb}, 32'b110);
    step(1'b0);
    check_eq("lw_rd0", {28'd0, state}, 32'd3);
    check_eq("lw_rd_mr_iord", {30'd0, memread, iord}, 32'd3);
    step(1'b0);
    step(1'b0);
    check_eq("lw_rd2", {28'd0, state}, 32'd3);
    step(1'b1);
    check_eq("lw_rd3", {28'd0, state}, 32'd3);
    step(1'b1);
    check_eq("lw_wb", {28'd0, state}, 32'd4);
    check_eq("lw_wb_rw_m2r", {30'd0, regwrite, memtoreg}, 32'd3);
    check_eq("lw_ir_pulses", ir_cnt, 32'd1);

    // asynchronous reset in the middle of MEMWB
    reset = 1'b1;
    #1;
    check_eq("rst_mid_ctl", {15'd0, ctl}, 32'd0);
    check_eq("rst_mid_state", {28'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_rel_state", {28'd0, state}, 32'd0);
    check_eq("rst_rel_memread", {31'd0, memread}, 32'd1);

    // sw with one stall in MEMWR
    op = 6'b101011;
    clr_cnt();
    step(1'b1);
    check_eq("sw_dec", {28'd0, state}, 32'd1);
    step(1'b0);
    check_eq("sw_madr", {28'd0, state}, 32'd2);
    step(1'b0);
    check_eq("sw_wr0", {28'd0, state}, 32'd5);
    check_eq("sw_wr_iord", {31'd0, iord}, 32'd1);
    step(1'b1);
    check_eq("sw_wr1", {28'd0, state}, 32'd5);
    step(1'b1);
    check_eq("sw_back", {28'd0, state}, 32'd0);
    check_eq("sw_mw_cycles", mw_cnt, 32'd2);
    check_eq("sw_no_rw", rw_cnt, 32'd0);

    // beq
    op = 6'b000100;
    clr_cnt();
    step(1'b1);
    step(1'b1);
    check_eq("beq_state", {28'd0, state}, 32'd8);
    check_eq("beq_aluop", {30'd0, aluop}, 32'd1);
    check_eq("beq_pcsrc", {30'd0, pcsource}, 32'd1);
    check_eq("beq_pcw", {31'd0, pcwrite}, 32'd0);
    step(1'b1);
    check_eq("beq_back", {28'd0, state}, 32'd0);
    check_eq("beq_pwc_once", pwc_cnt, 32'd1);

    // j
    op = 6'b000010;
    step(1'b1);
    step(1'b1);
    check_eq("j_state", {28'd0, state}, 32'd9);
    check_eq("j_pcw_src", {29'd0, pcwrite, pcsource}, 32'b110);
    step(1'b1);
    check_eq("j_back", {28'd0, state}, 32'd0);

    // addi
    op = 6'b001000;
    step(1'b1);
    step(1'b1);
    check_eq("addi_ex", {28'd0, state}, 32'd10);
    check_eq("addi_srcb", {30'd0, alusrcb}, 32'd2);
    step(1'b1);
    check_eq("addi_wb", {28'd0, state}, 32'd11);
    check_eq("addi_rw_rd", {30'd0, regwrite, regdst}, 32'b10);
    step(1'b1);
    check_eq("addi_back", {28'd0, state}, 32'd0);

    // illegal opcode
    op = 6'b111111;
    step(1'b1);
    check_eq("ill_dec", {28'd0, state}, 32'd1);
    check_eq("ill_pulse", {31'd0, illegal_op}, 32'd1);
    check_eq("ill_strobes", {27'd0, pcwrite, pcwritecond, memwrite, regwrite, irwrite}, 32'd0);
    step(1'b1);
    check_eq("ill_back", {28'd0, state}, 32'd0);
    check_eq("ill_end", {31'd0, illegal_op}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
